// File: rtl/gmii_send_pkg.sv
// rtl/gmii_send_pkg.sv - shared constants, state encoding and helpers for gmii_send
package gmii_send_pkg;

  localparam logic [7:0]  PREAMBLE_BYTE = 8'h55;
  localparam logic [7:0]  SFD_BYTE      = 8'hD5;
  localparam logic [3:0]  PREAMBLE_LEN  = 4'd7;
  localparam logic [3:0]  IFG_LEN       = 4'd12;
  localparam logic [10:0] MIN_FRAME_LEN = 11'd60;
  localparam logic [10:0] BYTE_CNT_MAX  = 11'd2047;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    PREAMBLE = 3'd1,
    DATA     = 3'd2,
    PAD      = 3'd3,
    DISCARD  = 3'd4,
    IFG      = 3'd5
  } send_state_t;

  function automatic logic [10:0] sat_inc(input logic [10:0] v);
    return (v == BYTE_CNT_MAX) ? v : v + 11'd1;
  endfunction

endpackage

// File: rtl/gmii_send.sv
// rtl/gmii_send.sv - GMII frame sender draining a show-ahead 9-bit FIFO
// Optional padding of short frames to 60 bytes: define GMII_SEND_PAD_EN.
module gmii_send
  import gmii_send_pkg::*;
(
  input  logic       clk_gmii_tx,
  input  logic       reset_n,
  input  logic [8:0] iv_data,
  input  logic       i_data_empty,
  output logic       o_data_rd,
  output logic [7:0] ov_gmii_txd,
  output logic       o_gmii_tx_en,
  output logic       o_gmii_tx_er,
  output logic       o_pkt_sent_pulse,
  output logic       o_fifo_underflow_pulse,
  output logic [2:0] ov_send_state
);

  send_state_t state;
  logic [3:0]  phase_cnt;
  logic [10:0] byte_cnt;
  logic        head_seen;

  assign ov_send_state = state;

  // A head word in IDLE is left in the FIFO so DATA pops it as the first byte.
  always_comb begin
    o_data_rd = 1'b0;
    if (reset_n && !i_data_empty) begin
      case (state)
        IDLE:    o_data_rd = ~iv_data[8];
        DATA:    o_data_rd = 1'b1;
        DISCARD: o_data_rd = 1'b1;
        default: o_data_rd = 1'b0;
      endcase
    end
  end

  always_ff @(posedge clk_gmii_tx or negedge reset_n) begin
    if (!reset_n) begin
      state                  <= IDLE;
      phase_cnt              <= 4'd0;
      byte_cnt               <= 11'd0;
      head_seen              <= 1'b0;
      ov_gmii_txd            <= 8'h00;
      o_gmii_tx_en           <= 1'b0;
      o_gmii_tx_er           <= 1'b0;
      o_pkt_sent_pulse       <= 1'b0;
      o_fifo_underflow_pulse <= 1'b0;
    end else begin
      ov_gmii_txd            <= 8'h00;
      o_gmii_tx_en           <= 1'b0;
      o_gmii_tx_er           <= 1'b0;
      o_pkt_sent_pulse       <= 1'b0;
      o_fifo_underflow_pulse <= 1'b0;

      case (state)
        IDLE: begin
          // First preamble byte goes out here so the IFG on the wire is exactly IFG_LEN.
          if (!i_data_empty && iv_data[8]) begin
            ov_gmii_txd  <= PREAMBLE_BYTE;
            o_gmii_tx_en <= 1'b1;
            phase_cnt    <= 4'd1;
            byte_cnt     <= 11'd0;
            head_seen    <= 1'b0;
            state        <= PREAMBLE;
          end
        end

        PREAMBLE: begin
          o_gmii_tx_en <= 1'b1;
          if (phase_cnt == PREAMBLE_LEN) begin
            ov_gmii_txd <= SFD_BYTE;
            state       <= DATA;
          end else begin
            ov_gmii_txd <= PREAMBLE_BYTE;
            phase_cnt   <= phase_cnt + 4'd1;
          end
        end

        DATA: begin
          o_gmii_tx_en <= 1'b1;
          if (!i_data_empty) begin
            ov_gmii_txd <= iv_data[7:0];
            byte_cnt    <= sat_inc(byte_cnt);
            head_seen   <= 1'b1;
            if (iv_data[8] && head_seen) begin
`ifdef GMII_SEND_PAD_EN
              if (sat_inc(byte_cnt) < MIN_FRAME_LEN) begin
                state <= PAD;
              end else begin
                o_pkt_sent_pulse <= 1'b1;
                phase_cnt        <= 4'd0;
                state            <= IFG;
              end
`else
              o_pkt_sent_pulse <= 1'b1;
              phase_cnt        <= 4'd0;
              state            <= IFG;
`endif
            end
          end else begin
            o_gmii_tx_er           <= 1'b1;
            o_fifo_underflow_pulse <= 1'b1;
            state                  <= DISCARD;
          end
        end

`ifdef GMII_SEND_PAD_EN
        PAD: begin
          o_gmii_tx_en <= 1'b1;
          byte_cnt     <= sat_inc(byte_cnt);
          if (sat_inc(byte_cnt) == MIN_FRAME_LEN) begin
            o_pkt_sent_pulse <= 1'b1;
            phase_cnt        <= 4'd0;
            state            <= IFG;
          end
        end
`endif

        DISCARD: begin
          // An underflow before the head was popped must not mistake the head for the tail.
          if (!i_data_empty) begin
            head_seen <= 1'b1;
            if (iv_data[8] && head_seen) begin
              phase_cnt <= 4'd0;
              state     <= IFG;
            end
          end
        end

        IFG: begin
          if (phase_cnt == IFG_LEN - 4'd1) begin
            state <= IDLE;
          end else begin
            phase_cnt <= phase_cnt + 4'd1;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_gmii_send.sv
// tb/tb_gmii_send.sv - scoreboard bench for gmii_send with a queue-modelled show-ahead FIFO
module tb_gmii_send;
  import gmii_send_pkg::*;

  logic       clk = 1'b0;
  logic       reset_n;
  logic [8:0] iv_data;
  logic       i_data_empty;
  logic       o_data_rd;
  logic [7:0] ov_gmii_txd;
  logic       o_gmii_tx_en;
  logic       o_gmii_tx_er;
  logic       o_pkt_sent_pulse;
  logic       o_fifo_underflow_pulse;
  logic [2:0] ov_send_state;

  gmii_send dut (
    .clk_gmii_tx            (clk),
    .reset_n                (reset_n),
    .iv_data                (iv_data),
    .i_data_empty           (i_data_empty),
    .o_data_rd              (o_data_rd),
    .ov_gmii_txd            (ov_gmii_txd),
    .o_gmii_tx_en           (o_gmii_tx_en),
    .o_gmii_tx_er           (o_gmii_tx_er),
    .o_pkt_sent_pulse       (o_pkt_sent_pulse),
    .o_fifo_underflow_pulse (o_fifo_underflow_pulse),
    .ov_send_state          (ov_send_state)
  );

  always #4 clk = ~clk;

  typedef struct packed {
    logic [7:0] txd;
    logic       er;
    logic       sent;
  } exp_t;

  exp_t       exp_q[$];
  logic [8:0] fifo_q[$];
  int checks = 0, errors = 0;
  int pop_total = 0, tx_cycles = 0, sent_cnt = 0, uflow_cnt = 0;
  int low_run = 0, last_gap = -1, stall_limit = -1;
  bit stall = 1'b0;
  logic prev_en = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, expv);
    end
  endtask

  task automatic drive_in();
    i_data_empty = stall || (fifo_q.size() == 0);
    iv_data      = (fifo_q.size() == 0) ? 9'h000 : fifo_q[0];
  endtask

  task automatic push_frame(input int len, input int base, input bit tail_mark);
    for (int i = 0; i < len; i++) begin
      logic [7:0] b;
      b = 8'(base + i);
      if (i == 0)             fifo_q.push_back({1'b1, b});
      else if (i == len - 1)  fifo_q.push_back({tail_mark, b});
      else                    fifo_q.push_back({1'b0, b});
    end
    drive_in();
  endtask

  task automatic exp_push(input logic [7:0] d, input logic er, input logic sent);
    exp_t e;
    e.txd = d; e.er = er; e.sent = sent;
    exp_q.push_back(e);
  endtask

  task automatic exp_preamble();
    for (int i = 0; i < 7; i++) exp_push(8'h55, 1'b0, 1'b0);
    exp_push(8'hD5, 1'b0, 1'b0);
  endtask

  task automatic exp_bytes(input int base, input int n, input bit last_sent);
    for (int i = 0; i < n; i++) exp_push(8'(base + i), 1'b0, last_sent && (i == n - 1));
  endtask

  // One clock: check the wire at negedge, then apply the FIFO pop after the edge.
  task automatic cycle();
    logic rd;
    exp_t e;
    @(negedge clk);
    rd = o_data_rd;
    if (o_data_rd) chk("rd_gated_by_empty", i_data_empty, 1'b0);
    if (o_gmii_tx_en) begin
      tx_cycles++;
      if (!prev_en) last_gap = low_run;
      low_run = 0;
      if (exp_q.size() == 0) begin
        chk("unexpected_tx_en", o_gmii_tx_en, 1'b0);
      end else begin
        e = exp_q.pop_front();
        chk("txd", ov_gmii_txd, e.txd);
        chk("tx_er", o_gmii_tx_er, e.er);
        chk("uflow_pulse", o_fifo_underflow_pulse, e.er);
        chk("sent_pulse", o_pkt_sent_pulse, e.sent);
      end
    end else begin
      low_run++;
      chk("idle_txd", ov_gmii_txd, 8'h00);
      chk("idle_tx_er", o_gmii_tx_er, 1'b0);
      chk("idle_sent", o_pkt_sent_pulse, 1'b0);
      chk("idle_uflow", o_fifo_underflow_pulse, 1'b0);
    end
    prev_en = o_gmii_tx_en;
    if (o_pkt_sent_pulse) sent_cnt++;
    if (o_fifo_underflow_pulse) uflow_cnt++;
    @(posedge clk);
    #1;
    if (rd && fifo_q.size() > 0) begin
      void'(fifo_q.pop_front());
      pop_total++;
      if (stall_limit >= 0 && pop_total == stall_limit) begin
        stall = 1'b1;
        stall_limit = -1;
      end
    end
    drive_in();
  endtask

  task automatic wait_done(input string tag);
    int n = 0;
    while (!(fifo_q.size() == 0 && exp_q.size() == 0 && ov_send_state == IDLE) && n < 3000) begin
      cycle();
      n++;
    end
    chk({tag, "_done"}, (n < 3000), 1'b1);
  endtask

  initial begin
    int t0, s0, u0, p0, n;
    exp_t e;

    reset_n = 1'b0;
    fifo_q.push_back(9'h011);
    fifo_q.push_back(9'h022);
    drive_in();
    #2;
    chk("rst_txd", ov_gmii_txd, 8'h00);
    chk("rst_tx_en", o_gmii_tx_en, 1'b0);
    chk("rst_tx_er", o_gmii_tx_er, 1'b0);
    chk("rst_sent", o_pkt_sent_pulse, 1'b0);
    chk("rst_uflow", o_fifo_underflow_pulse, 1'b0);
    chk("rst_rd", o_data_rd, 1'b0);
    chk("rst_state", ov_send_state, 3'd0);
    repeat (3) cycle();
    chk("rst_no_pop", fifo_q.size(), 2);
    reset_n = 1'b1;

    // Orphan words in IDLE are dropped without transmitting
    t0 = tx_cycles;
    repeat (6) cycle();
    chk("orphan_fifo_empty", fifo_q.size(), 0);
    chk("orphan_pops", pop_total, 2);
    chk("orphan_no_tx", tx_cycles - t0, 0);

    // Single 64-byte frame
    t0 = tx_cycles; s0 = sent_cnt;
    push_frame(64, 0, 1'b1);
    exp_preamble(); exp_bytes(0, 64, 1'b1);
    wait_done("single64");
    chk("single64_tx_cycles", tx_cycles - t0, 72);
    chk("single64_sent", sent_cnt - s0, 1);

    // Back-to-back frames: 12-cycle gap on the wire
    t0 = tx_cycles; s0 = sent_cnt;
    push_frame(64, 8'h40, 1'b1);
    push_frame(64, 8'h80, 1'b1);
    exp_preamble(); exp_bytes(8'h40, 64, 1'b1);
    exp_preamble(); exp_bytes(8'h80, 64, 1'b1);
    wait_done("b2b");
    chk("b2b_gap", last_gap, 12);
    chk("b2b_tx_cycles", tx_cycles - t0, 144);
    chk("b2b_sent", sent_cnt - s0, 2);

    // Underflow after 21 bytes popped
    t0 = tx_cycles; s0 = sent_cnt; u0 = uflow_cnt;
    stall_limit = pop_total + 21;
    push_frame(64, 0, 1'b1);
    exp_preamble(); exp_bytes(0, 21, 1'b0); exp_push(8'h00, 1'b1, 1'b0);
    n = 0;
    while (!stall && n < 200) begin cycle(); n++; end
    chk("uflow_stall_reached", stall, 1'b1);
    repeat (4) cycle();
    chk("uflow_err_slot_seen", exp_q.size(), 0);
    p0 = pop_total;
    stall = 1'b0;
    drive_in();
    wait_done("uflow");
    chk("uflow_discarded", pop_total - p0, 43);
    chk("uflow_pulses", uflow_cnt - u0, 1);
    chk("uflow_no_sent", sent_cnt - s0, 0);
    chk("uflow_tx_cycles", tx_cycles - t0, 30);

    // Short 20-byte frame
    t0 = tx_cycles; s0 = sent_cnt;
    push_frame(20, 8'hA0, 1'b1);
    exp_preamble();
`ifdef GMII_SEND_PAD_EN
    exp_bytes(8'hA0, 20, 1'b0);
    for (int i = 0; i < 40; i++) exp_push(8'h00, 1'b0, i == 39);
`else
    exp_bytes(8'hA0, 20, 1'b1);
`endif
    wait_done("short20");
`ifdef GMII_SEND_PAD_EN
    chk("short20_tx_cycles", tx_cycles - t0, 68);
`else
    chk("short20_tx_cycles", tx_cycles - t0, 28);
`endif
    chk("short20_sent", sent_cnt - s0, 1);

    // Reset mid-frame; remaining tail-less words are dropped afterwards
    p0 = pop_total;
    push_frame(64, 0, 1'b0);
    exp_preamble(); exp_bytes(0, 30, 1'b0);
    n = 0;
    while (pop_total < p0 + 30 && n < 200) begin cycle(); n++; end
    chk("midrst_reached", pop_total - p0, 30);
    e = exp_q.pop_front();
    chk("midrst_pre_txd", ov_gmii_txd, e.txd);
    chk("midrst_pre_en", o_gmii_tx_en, 1'b1);
    reset_n = 1'b0;
    #1;
    chk("midrst_en", o_gmii_tx_en, 1'b0);
    chk("midrst_txd", ov_gmii_txd, 8'h00);
    chk("midrst_rd", o_data_rd, 1'b0);
    chk("midrst_state", ov_send_state, 3'd0);
    chk("midrst_exp_drained", exp_q.size(), 0);
    chk("midrst_fifo_left", fifo_q.size(), 34);
    repeat (2) cycle();
    reset_n = 1'b1;
    t0 = tx_cycles; p0 = pop_total;
    repeat (40) cycle();
    chk("midrst_dropped", pop_total - p0, 34);
    chk("midrst_no_tx", tx_cycles - t0, 0);
    s0 = sent_cnt;
    push_frame(64, 8'h30, 1'b1);
    exp_preamble(); exp_bytes(8'h30, 64, 1'b1);
    wait_done("post_rst");
    chk("post_rst_sent", sent_cnt - s0, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
